// File: rtl/cpu_ctrl_pkg.sv
// Shared types and encodings for the accumulator CPU control unit.
package cpu_ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH0, S_DECODE, S_FETCH1, S_FETCH2, S_JUMP,
        S_MEM_RD, S_EXEC_M, S_WB_M,
        S_ST_A,   S_ST_EX,  S_ST_WR,
        S_REG_RA, S_REG_RB, S_REG_EX, S_REG_WB,
        S_HALT
    } state_t;

    localparam logic [3:0] OP_JMP = 4'b1000;
    localparam logic [3:0] OP_JZ  = 4'b1001;
    localparam logic [3:0] OP_JC  = 4'b1010;
    localparam logic [3:0] OP_HLT = 4'b1011;

    // memory-reference sub-op lives in opcode[2:1]
    localparam logic [1:0] MOP_LDA = 2'b00;
    localparam logic [1:0] MOP_STA = 2'b01;
    localparam logic [1:0] MOP_ADD = 2'b10;
    localparam logic [1:0] MOP_AND = 2'b11;

    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_ADC = 2'b01;
    localparam logic [1:0] ALU_AND = 2'b10;
    localparam logic [1:0] ALU_NOT = 2'b11;

    localparam logic [1:0] ACC_DI = 2'b00;
    localparam logic [1:0] ACC_RS = 2'b01;
    localparam logic [1:0] ACC_RD = 2'b10;

    localparam int FLAG_C = 0;
    localparam int FLAG_Z = 1;
    localparam int FLAG_N = 2;

    typedef struct packed {
        logic       pc_inc;
        logic       pc_load_en;
        logic       di_load_en;
        logic       ir_write_en;
        logic       tr_write_en;
        logic       a_reg_write_en;
        logic       b_reg_write_en;
        logic       alu_res_write_en;
        logic       ld_czn;
        logic       acc_write_en;
        logic       mem_read_en;
        logic       mem_write_en;
        logic       pc_or_tr;
        logic       reg_or_mem;
        logic       reg_b_or_0;
        logic       reg_a_or_0;
        logic [1:0] acc_addr_sel;
        logic [1:0] alu_op;
    } ctrl_out_t;

    function automatic logic is_reg_op(input logic [3:0] op);
        return op[3:2] == 2'b11;
    endfunction

endpackage

// File: rtl/ctrl_output_decode.sv
// Moore output decode: current state plus latched opcode to datapath strobes.
module ctrl_output_decode
    import cpu_ctrl_pkg::*;
(
    input  state_t      state,
    input  logic [2:0]  opcode,
    output ctrl_out_t   outs
);

    always_comb begin
        outs = '0;
        case (state)
            S_FETCH0, S_FETCH1: begin
                outs.pc_or_tr    = 1'b1;
                outs.mem_read_en = 1'b1;
                outs.ir_write_en = 1'b1;
                outs.pc_inc      = 1'b1;
            end
            S_DECODE: outs.di_load_en = 1'b1;
            S_FETCH2: begin
                outs.pc_or_tr    = 1'b1;
                outs.mem_read_en = 1'b1;
                outs.tr_write_en = 1'b1;
                outs.pc_inc      = 1'b1;
            end
            S_JUMP: outs.pc_load_en = 1'b1;
            S_MEM_RD: begin
                outs.mem_read_en    = 1'b1;
                outs.b_reg_write_en = 1'b1;
                outs.acc_addr_sel   = ACC_DI;
                outs.a_reg_write_en = 1'b1;
            end
            S_EXEC_M: begin
                outs.alu_res_write_en = 1'b1;
                case (opcode[2:1])
                    MOP_LDA: begin
                        outs.alu_op     = ALU_ADD;
                        outs.reg_a_or_0 = 1'b1;
                    end
                    MOP_ADD: begin
                        outs.alu_op = ALU_ADD;
                        outs.ld_czn = 1'b1;
                    end
                    MOP_AND: begin
                        outs.alu_op = ALU_AND;
                        outs.ld_czn = 1'b1;
                    end
                    default: ;
                endcase
            end
            S_WB_M: begin
                outs.acc_addr_sel = ACC_DI;
                outs.acc_write_en = 1'b1;
            end
            S_ST_A: begin
                outs.acc_addr_sel   = ACC_DI;
                outs.a_reg_write_en = 1'b1;
            end
            S_ST_EX: begin
                outs.reg_b_or_0       = 1'b1;
                outs.alu_op           = ALU_ADD;
                outs.alu_res_write_en = 1'b1;
            end
            S_ST_WR: outs.mem_write_en = 1'b1;
            S_REG_RA: begin
                outs.acc_addr_sel   = ACC_RD;
                outs.a_reg_write_en = 1'b1;
            end
            S_REG_RB: begin
                outs.acc_addr_sel   = ACC_RS;
                outs.reg_or_mem     = 1'b1;
                outs.b_reg_write_en = 1'b1;
            end
            S_REG_EX: begin
                outs.alu_op           = opcode[1:0];
                outs.alu_res_write_en = 1'b1;
                outs.ld_czn           = 1'b1;
            end
            S_REG_WB: begin
                outs.acc_addr_sel = ACC_RD;
                outs.acc_write_en = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/control_unit.sv
// Multi-cycle control FSM for the 8-bit accumulator CPU: state register,
// opcode latch and next-state logic; strobes come from ctrl_output_decode.
//   FETCH0/FETCH1/FETCH2 | read byte0 / byte1 into IR / byte2 into TR
//   DECODE | load DI, latch opcode      JUMP   | load PC from TR
//   MEM_RD/EXEC_M/WB_M   | LDA/ADD/AND  ST_A/ST_EX/ST_WR | STA
//   REG_RA/RB/EX/WB      | register op  HALT   | idle until rst
module control_unit
    import cpu_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] IrToCU,
    input  logic [4:0] DiToCU,
    input  logic [2:0] CznToCU,
    output logic       pcInc,
    output logic       pcLoadEn,
    output logic       diLoadEn,
    output logic       irWriteEn,
    output logic       trWriteEn,
    output logic       aRegWriteEn,
    output logic       bRegWriteEn,
    output logic       aluResWriteEn,
    output logic       ldCZN,
    output logic       accumulatorWriteEn,
    output logic       memoryReadEn,
    output logic       memoryWriteEn,
    output logic       PcOrTR,
    output logic       regOrMem,
    output logic       RegBOr0,
    output logic       RegAOr0,
    output logic [1:0] accAddressSel,
    output logic [1:0] aluOpControl
);

    state_t     state;
    logic [3:0] opcode;
    ctrl_out_t  dec_outs;
    ctrl_out_t  outs;
    logic       unused_inputs;

    // DI and N are routed by the datapath; the sequencer never branches on them
    assign unused_inputs = ^{DiToCU, CznToCU[FLAG_N]};

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= S_FETCH0;
            opcode <= 4'b0000;
        end else begin
            case (state)
                S_FETCH0: state <= S_DECODE;
                S_DECODE: begin
                    opcode <= IrToCU;
                    if (IrToCU == OP_HLT)
                        state <= S_HALT;
                    else if (is_reg_op(IrToCU))
                        state <= S_REG_RA;
                    else
                        state <= S_FETCH1;
                end
                S_FETCH1: state <= S_FETCH2;
                S_FETCH2: begin
                    if (!opcode[3])
                        state <= (opcode[2:1] == MOP_STA) ? S_ST_A : S_MEM_RD;
                    else if (opcode == OP_JMP)
                        state <= S_JUMP;
                    else if (opcode == OP_JZ)
                        state <= CznToCU[FLAG_Z] ? S_JUMP : S_FETCH0;
                    else if (opcode == OP_JC)
                        state <= CznToCU[FLAG_C] ? S_JUMP : S_FETCH0;
                    else
                        state <= S_FETCH0;
                end
                S_JUMP:   state <= S_FETCH0;
                S_MEM_RD: state <= S_EXEC_M;
                S_EXEC_M: state <= S_WB_M;
                S_WB_M:   state <= S_FETCH0;
                S_ST_A:   state <= S_ST_EX;
                S_ST_EX:  state <= S_ST_WR;
                S_ST_WR:  state <= S_FETCH0;
                S_REG_RA: state <= S_REG_RB;
                S_REG_RB: state <= S_REG_EX;
                S_REG_EX: state <= S_REG_WB;
                S_REG_WB: state <= S_FETCH0;
                default:  state <= S_HALT;
            endcase
        end
    end

    ctrl_output_decode u_decode (
        .state  (state),
        .opcode (opcode[2:0]),
        .outs   (dec_outs)
    );

    assign outs = rst ? '0 : dec_outs;

    assign pcInc              = outs.pc_inc;
    assign pcLoadEn           = outs.pc_load_en;
    assign diLoadEn           = outs.di_load_en;
    assign irWriteEn          = outs.ir_write_en;
    assign trWriteEn          = outs.tr_write_en;
    assign aRegWriteEn        = outs.a_reg_write_en;
    assign bRegWriteEn        = outs.b_reg_write_en;
    assign aluResWriteEn      = outs.alu_res_write_en;
    assign ldCZN              = outs.ld_czn;
    assign accumulatorWriteEn = outs.acc_write_en;
    assign memoryReadEn       = outs.mem_read_en;
    assign memoryWriteEn      = outs.mem_write_en;
    assign PcOrTR             = outs.pc_or_tr;
    assign regOrMem           = outs.reg_or_mem;
    assign RegBOr0            = outs.reg_b_or_0;
    assign RegAOr0            = outs.reg_a_or_0;
    assign accAddressSel      = outs.acc_addr_sel;
    assign aluOpControl       = outs.alu_op;

endmodule

// File: tb/tb_control_unit.sv
// Directed bench for control_unit: per-cycle strobe vectors for each instruction class.
module tb_control_unit;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] IrToCU = 4'h0;
    logic [4:0] DiToCU = 5'h00;
    logic [2:0] CznToCU = 3'b000;

    logic pcInc, pcLoadEn, diLoadEn, irWriteEn, trWriteEn, aRegWriteEn, bRegWriteEn;
    logic aluResWriteEn, ldCZN, accumulatorWriteEn, memoryReadEn, memoryWriteEn;
    logic PcOrTR, regOrMem, RegBOr0, RegAOr0;
    logic [1:0] accAddressSel, aluOpControl;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    control_unit dut (
        .clk(clk), .rst(rst), .IrToCU(IrToCU), .DiToCU(DiToCU), .CznToCU(CznToCU),
        .pcInc(pcInc), .pcLoadEn(pcLoadEn), .diLoadEn(diLoadEn), .irWriteEn(irWriteEn),
        .trWriteEn(trWriteEn), .aRegWriteEn(aRegWriteEn), .bRegWriteEn(bRegWriteEn),
        .aluResWriteEn(aluResWriteEn), .ldCZN(ldCZN), .accumulatorWriteEn(accumulatorWriteEn),
        .memoryReadEn(memoryReadEn), .memoryWriteEn(memoryWriteEn), .PcOrTR(PcOrTR),
        .regOrMem(regOrMem), .RegBOr0(RegBOr0), .RegAOr0(RegAOr0),
        .accAddressSel(accAddressSel), .aluOpControl(aluOpControl)
    );

    wire [19:0] obs = {pcInc, pcLoadEn, diLoadEn, irWriteEn, trWriteEn, aRegWriteEn,
                       bRegWriteEn, aluResWriteEn, ldCZN, accumulatorWriteEn, memoryReadEn,
                       memoryWriteEn, PcOrTR, regOrMem, RegBOr0, RegAOr0,
                       accAddressSel, aluOpControl};

    // one-hot masks matching the obs packing
    localparam logic [19:0] M_PCINC = 20'h80000, M_PCLD = 20'h40000, M_DIL  = 20'h20000;
    localparam logic [19:0] M_IRW   = 20'h10000, M_TRW  = 20'h08000, M_ARW  = 20'h04000;
    localparam logic [19:0] M_BRW   = 20'h02000, M_ALUW = 20'h01000, M_CZN  = 20'h00800;
    localparam logic [19:0] M_ACCW  = 20'h00400, M_MRD  = 20'h00200, M_MWR  = 20'h00100;
    localparam logic [19:0] M_PCSEL = 20'h00080, M_RORM = 20'h00040, M_BOR0 = 20'h00020;
    localparam logic [19:0] M_AOR0  = 20'h00010, M_SEL_RD = 20'h00008, M_SEL_RS = 20'h00004;
    localparam logic [19:0] M_ALU_ADC = 20'h00001, M_ALU_AND = 20'h00002;

    localparam logic [19:0] E_F0    = M_PCSEL | M_MRD | M_IRW | M_PCINC;
    localparam logic [19:0] E_DEC   = M_DIL;
    localparam logic [19:0] E_F2    = M_PCSEL | M_MRD | M_TRW | M_PCINC;
    localparam logic [19:0] E_JUMP  = M_PCLD;
    localparam logic [19:0] E_MEMRD = M_MRD | M_BRW | M_ARW;
    localparam logic [19:0] E_XLDA  = M_ALUW | M_AOR0;
    localparam logic [19:0] E_XADD  = M_ALUW | M_CZN;
    localparam logic [19:0] E_WBM   = M_ACCW;
    localparam logic [19:0] E_STA   = M_ARW;
    localparam logic [19:0] E_STEX  = M_BOR0 | M_ALUW;
    localparam logic [19:0] E_STWR  = M_MWR;
    localparam logic [19:0] E_RA    = M_ARW | M_SEL_RD;
    localparam logic [19:0] E_RB    = M_BRW | M_RORM | M_SEL_RS;
    localparam logic [19:0] E_RWB   = M_ACCW | M_SEL_RD;

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            IrToCU = 4'hD;
            #1;
            checks++;
            if (obs !== 20'h0) begin
                errors++;
                $display("FAIL reset_hold cycle %0d: got %05h expected %05h", i, obs, 20'h0);
            end
        end
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        #1;
        checks++;
        if (obs !== E_F0) begin
            errors++;
            $display("FAIL reset_release: got %05h expected %05h", obs, E_F0);
        end
    endtask

    // LDA acc2 from 0x1A5C: bytes 0x10, 0x1A, 0x5C
    task automatic test_lda();
        logic [19:0] ev [8];
        logic [3:0]  irv [8];
        ev  = '{E_F0, E_DEC, E_F0, E_F2, E_MEMRD, E_XLDA, E_WBM, E_F0};
        irv = '{4'h0, 4'h1, 4'h1, 4'h1, 4'h1, 4'h1, 4'h1, 4'h1};
        do_reset();
        DiToCU = 5'b10000;
        CznToCU = 3'b111;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            IrToCU = irv[i];
            #1;
            checks++;
            if (obs !== ev[i]) begin
                errors++;
                $display("FAIL lda cycle %0d: got %05h expected %05h", i, obs, ev[i]);
            end
        end
    endtask

    // ADD acc0 from 0x1234: bytes 0x40, 0x12, 0x34; live IR nibble 1 during EXEC must be ignored
    task automatic test_mem_add();
        logic [19:0] ev [8];
        logic [3:0]  irv [8];
        ev  = '{E_F0, E_DEC, E_F0, E_F2, E_MEMRD, E_XADD, E_WBM, E_F0};
        irv = '{4'h0, 4'h4, 4'h4, 4'h1, 4'h1, 4'h1, 4'h1, 4'h1};
        do_reset();
        DiToCU = 5'b00000;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            IrToCU = irv[i];
            #1;
            checks++;
            if (obs !== ev[i]) begin
                errors++;
                $display("FAIL mem_add cycle %0d: got %05h expected %05h", i, obs, ev[i]);
            end
        end
    endtask

    // STA acc1 to 0x0003: bytes 0x28, 0x00, 0x03; byte1 nibble 0 looks like LDA if decoded live
    task automatic test_sta();
        logic [19:0] ev [8];
        logic [3:0]  irv [8];
        ev  = '{E_F0, E_DEC, E_F0, E_F2, E_STA, E_STEX, E_STWR, E_F0};
        irv = '{4'h0, 4'h2, 4'h2, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0};
        do_reset();
        DiToCU = 5'b01000;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            IrToCU = irv[i];
            #1;
            checks++;
            if (obs !== ev[i]) begin
                errors++;
                $display("FAIL sta cycle %0d: got %05h expected %05h", i, obs, ev[i]);
            end
        end
    endtask

    task automatic test_branch(input logic [3:0] op, input logic [2:0] flags, input bit taken);
        logic [19:0] ev [6];
        logic [3:0]  irv [6];
        int n;
        if (taken) ev = '{E_F0, E_DEC, E_F0, E_F2, E_JUMP, E_F0};
        else       ev = '{E_F0, E_DEC, E_F0, E_F2, E_F0, E_DEC};
        n = taken ? 6 : 5;
        irv = '{4'h0, op, op, 4'h0, 4'h0, 4'h0};
        do_reset();
        CznToCU = flags;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            IrToCU = irv[i];
            #1;
            checks++;
            if (obs !== ev[i]) begin
                errors++;
                $display("FAIL branch op=%h czn=%b cycle %0d: got %05h expected %05h",
                         op, flags, i, obs, ev[i]);
            end
        end
    endtask

    // ADC r3 <- r3 + r0: byte0 0xDC
    task automatic test_reg_adc();
        logic [19:0] ev [7];
        ev = '{E_F0, E_DEC, E_RA, E_RB, (M_ALUW | M_CZN | M_ALU_ADC), E_RWB, E_F0};
        do_reset();
        CznToCU = 3'b000;
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            IrToCU = (i == 0) ? 4'h0 : 4'hD;
            #1;
            checks++;
            if (obs !== ev[i]) begin
                errors++;
                $display("FAIL reg_adc cycle %0d: got %05h expected %05h", i, obs, ev[i]);
            end
        end
    endtask

    task automatic test_halt();
        logic [19:0] e;
        do_reset();
        for (int i = 0; i < 22; i++) begin
            @(negedge clk);
            IrToCU = (i == 0) ? 4'h0 : 4'hB;
            e = (i == 0) ? E_F0 : (i == 1) ? E_DEC : 20'h0;
            #1;
            checks++;
            if (obs !== e) begin
                errors++;
                $display("FAIL halt cycle %0d: got %05h expected %05h", i, obs, e);
            end
        end
        do_reset();
        @(negedge clk);
        #1;
        checks++;
        if (obs !== E_F0) begin
            errors++;
            $display("FAIL halt_restart: got %05h expected %05h", obs, E_F0);
        end
    endtask

    // LDA aborted by rst in MEM_RD: outputs zero that cycle, then FETCH0
    task automatic test_abort();
        logic [19:0] ev [4];
        ev = '{E_F0, E_DEC, E_F0, E_F2};
        do_reset();
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            IrToCU = (i == 0) ? 4'h0 : 4'h1;
            #1;
            checks++;
            if (obs !== ev[i]) begin
                errors++;
                $display("FAIL abort_pre cycle %0d: got %05h expected %05h", i, obs, ev[i]);
            end
        end
        @(negedge clk);
        rst = 1'b1;
        #1;
        checks++;
        if (obs !== 20'h0) begin
            errors++;
            $display("FAIL abort_rst: got %05h expected %05h", obs, 20'h0);
        end
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        #1;
        checks++;
        if (obs !== E_F0) begin
            errors++;
            $display("FAIL abort_restart: got %05h expected %05h", obs, E_F0);
        end
    endtask

    // register AND (0xE4) immediately followed by a taken JC (0xA0), no reset in between
    task automatic test_back_to_back();
        logic [19:0] ev [12];
        logic [3:0]  irv [12];
        ev  = '{E_F0, E_DEC, E_RA, E_RB, (M_ALUW | M_CZN | M_ALU_AND), E_RWB,
                E_F0, E_DEC, E_F0, E_F2, E_JUMP, E_F0};
        irv = '{4'h0, 4'hE, 4'hE, 4'hE, 4'hE, 4'hE,
                4'hE, 4'hA, 4'hA, 4'h0, 4'h0, 4'h0};
        do_reset();
        CznToCU = 3'b001;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            IrToCU = irv[i];
            #1;
            checks++;
            if (obs !== ev[i]) begin
                errors++;
                $display("FAIL back_to_back cycle %0d: got %05h expected %05h", i, obs, ev[i]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_lda();
        test_mem_add();
        test_sta();
        test_branch(4'h9, 3'b010, 1'b1);
        test_branch(4'h9, 3'b000, 1'b0);
        test_branch(4'hA, 3'b001, 1'b1);
        test_branch(4'hA, 3'b010, 1'b0);
        test_branch(4'h8, 3'b000, 1'b1);
        test_reg_adc();
        test_halt();
        test_abort();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
